// File: rtl/zx_bus_pkg.sv
// Shared definitions for the Z80 I/O bus master.
//   - zx_state_e  : bus-cycle FSM states
//   - zx_req_t    : latched request (direction, port address, write data)
//   - T_CLKS_DEF / WAIT_MAX_DEF : default timing parameters
//   - STROBE_IDLE : {n_iorq, n_rd, n_wr} value outside the strobe window
package zx_bus_pkg;

    localparam int T_CLKS_DEF   = 9;
    localparam int WAIT_MAX_DEF = 255;

    // Tick counter covers T_CLKS up to 15; extension counter covers WAIT_MAX up to 255.
    localparam int TICK_W = 4;
    localparam int EXT_W  = 8;

    localparam logic [2:0] STROBE_IDLE = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_TW,
        ST_T3,
        ST_DONE
    } zx_state_e;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } zx_req_t;

endpackage

// File: rtl/zx_tstate_timer.sv
// T-state timer for the Z80 I/O master.
//   clk32, rst_n : clock / async active-low reset
//   run          : FSM is inside T1..T3; tick is held at 0 otherwise
//   ext_clr      : clear the TW extension count (new request accepted)
//   ext_inc      : one more TW extension is being inserted
//   tick         : position inside the current T-state, 0..T_CLKS-1
//   last         : current cycle is the last tick of a T-state
//   ext_cnt      : TW extensions inserted for the current request
module zx_tstate_timer import zx_bus_pkg::*; #(
    parameter int T_CLKS = T_CLKS_DEF
) (
    input  logic              clk32,
    input  logic              rst_n,
    input  logic              run,
    input  logic              ext_clr,
    input  logic              ext_inc,
    output logic [TICK_W-1:0] tick,
    output logic              last,
    output logic [EXT_W-1:0]  ext_cnt
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(T_CLKS - 1);

    assign last = run && (tick == TICK_LAST);

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n)
            tick <= '0;
        else if (!run || last)
            tick <= '0;
        else
            tick <= tick + 1'b1;
    end

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n)
            ext_cnt <= '0;
        else if (ext_clr)
            ext_cnt <= '0;
        else if (ext_inc)
            ext_cnt <= ext_cnt + 1'b1;
    end

endmodule

// File: rtl/zx_io_master.sv
// Z80 I/O bus master: turns one request into a T1/T2/TW/T3 I/O cycle.
//   Request side : req_valid/req_ready handshake, req_wr, req_addr, req_wdata
//   Response side: rsp_valid (one-cycle pulse), rsp_rdata, rsp_timeout
//   Z80 bus      : a, d_out/d_oe/d_in, n_iorq, n_rd, n_wr, n_m1, n_mreq, n_wait
// Bus strobes are decoded from the registered state so an asynchronous reset
// releases them in the same instant.
module zx_io_master import zx_bus_pkg::*; #(
    parameter int T_CLKS   = T_CLKS_DEF,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic        clk32,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic [15:0] a,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [7:0]  d_in,
    output logic        n_iorq,
    output logic        n_rd,
    output logic        n_wr,
    output logic        n_m1,
    output logic        n_mreq,
    input  logic        n_wait
);

    // Strobes stay low through T3 tick TICK_HALF-1; read data is captured then.
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(T_CLKS / 2);
    localparam logic [TICK_W-1:0] TICK_CAP  = TICK_W'(T_CLKS / 2 - 1);
    localparam logic [EXT_W-1:0]  EXT_MAX   = EXT_W'(WAIT_MAX);

    zx_state_e          state_q, state_d;
    zx_req_t            req_q;
    logic [1:0]         wait_sync;
    logic               wait_s;
    logic [TICK_W-1:0]  tick;
    logic               last;
    logic [EXT_W-1:0]   ext_cnt;
    logic               ext_inc;
    logic               accept;
    logic               run;
    logic               strobe_on;
    logic               cap_now;
    logic [7:0]         rdata_cap;
    logic               timeout_q;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign run       = (state_q == ST_T1) || (state_q == ST_T2) ||
                       (state_q == ST_TW) || (state_q == ST_T3);
    assign strobe_on = (state_q == ST_T2) || (state_q == ST_TW) ||
                       ((state_q == ST_T3) && (tick < TICK_HALF));
    assign cap_now   = (state_q == ST_T3) && (tick == TICK_CAP);
    assign wait_s    = wait_sync[1];

    assign {n_iorq, n_rd, n_wr} = strobe_on ? {1'b0, req_q.wr, !req_q.wr} : STROBE_IDLE;
    assign n_m1      = 1'b1;
    assign n_mreq    = 1'b1;
    assign a         = req_q.addr;
    assign d_out     = req_q.wdata;
    assign d_oe      = run && req_q.wr;
    assign rsp_valid = (state_q == ST_DONE);

    zx_tstate_timer #(.T_CLKS(T_CLKS)) u_timer (
        .clk32   (clk32),
        .rst_n   (rst_n),
        .run     (run),
        .ext_clr (accept),
        .ext_inc (ext_inc),
        .tick    (tick),
        .last    (last),
        .ext_cnt (ext_cnt)
    );

    // n_wait is asynchronous to clk32; resets to "not waiting".
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n)
            wait_sync <= 2'b11;
        else
            wait_sync <= {wait_sync[0], n_wait};
    end

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ext_inc = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_T1;
            ST_T1:   if (last) state_d = ST_T2;
            ST_T2:   if (last) state_d = ST_TW;
            ST_TW: begin
                if (last) begin
                    // Stay in TW for another T-state while the slave holds
                    // n_wait low, up to the extension budget.
                    if (!wait_s && (ext_cnt < EXT_MAX))
                        ext_inc = 1'b1;
                    else
                        state_d = ST_T3;
                end
            end
            ST_T3:   if (last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            req_q.wr    <= 1'b0;
            req_q.addr  <= '0;
            req_q.wdata <= '0;
        end else if (accept) begin
            req_q.wr    <= req_wr;
            req_q.addr  <= req_addr;
            req_q.wdata <= req_wdata;
        end
    end

    // Response fields only change on entry to DONE so they hold between pulses.
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            rdata_cap   <= 8'hFF;
            timeout_q   <= 1'b0;
            rsp_rdata   <= 8'hFF;
            rsp_timeout <= 1'b0;
        end else begin
            if (cap_now)
                rdata_cap <= d_in;
            // Leaving TW with wait still asserted means the budget ran out.
            if ((state_q == ST_TW) && (state_d == ST_T3))
                timeout_q <= !wait_s;
            if ((state_q == ST_T3) && (state_d == ST_DONE)) begin
                rsp_rdata   <= req_q.wr ? 8'hFF : rdata_cap;
                rsp_timeout <= timeout_q;
            end
        end
    end

endmodule
